// File: rtl/data_mem_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | data_mem_unit : MEM-stage byte-lane RAM plus MMIO window (GPIO, 64-bit    |
// | cycle counter with hi-word snapshot, sticky fault status/address). r1.0   |
// +--------------------------------------------------------------------------+
module data_mem_unit #(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter logic [31:0] MMIO_BASE   = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write_mem,
  input  logic        mem_read_mem,
  input  logic [2:0]  funct3_mem,
  input  logic [31:0] alu_result_mem,
  input  logic [31:0] write_data_mem,
  output logic [31:0] read_data_mem,
  output logic [31:0] gpio_out,
  output logic        fault
);

  localparam int unsigned AW        = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
  localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

  logic [31:0] mem_q [DEPTH_WORDS];

  logic [31:0] gpio_q, gpio_d;
  logic [63:0] cycle_q, cycle_d;
  logic [31:0] snap_q, snap_d;
  logic [1:0]  fstat_q, fstat_d;
  logic [31:0] faddr_q, faddr_d;

  logic          access, is_load, is_byte, is_half, is_word, f3_ok;
  logic          misalign, ram_hit, mmio_hit, decode_err, fault_mis, fault_dec, ok;
  logic [2:0]    mmio_sel;
  logic [AW-1:0] ram_idx;
  logic [31:0]   ram_word, lane_b, lane_h, ram_rdata, mmio_rdata;
  logic          ram_we;
  logic [3:0]    ram_be;
  logic [31:0]   ram_wdata;

  always_comb begin
    access   = mem_read_mem | mem_write_mem;
    is_load  = mem_read_mem & ~mem_write_mem;
    is_byte  = (funct3_mem[1:0] == 2'b00);
    is_half  = (funct3_mem[1:0] == 2'b01);
    is_word  = (funct3_mem == 3'b010);
    // Stores only accept SB/SH/SW; loads add LBU/LHU. Anything else is treated as misaligned.
    f3_ok    = mem_write_mem ? (~funct3_mem[2] & (funct3_mem[1:0] != 2'b11))
                             : ((funct3_mem != 3'b011) & (funct3_mem[2:1] != 2'b11));
    misalign = ~f3_ok | (is_half & alu_result_mem[0])
                      | (is_word & (alu_result_mem[1:0] != 2'b00));
    ram_hit    = ({1'b0, alu_result_mem} < RAM_BYTES);
    mmio_hit   = (alu_result_mem[31:5] == MMIO_BASE[31:5]);
    decode_err = ~(ram_hit | mmio_hit) | (mmio_hit & ~is_word);
    fault_mis  = access & misalign;
    fault_dec  = access & decode_err;
    ok         = access & ~misalign & ~decode_err;
    mmio_sel   = alu_result_mem[4:2];
    ram_idx    = alu_result_mem[AW+1:2];
  end

  always_comb begin
    ram_word = mem_q[ram_idx];
    lane_b   = ram_word >> {alu_result_mem[1:0], 3'b000};
    lane_h   = ram_word >> {alu_result_mem[1], 4'b0000};
    case (funct3_mem)
      3'b000:  ram_rdata = {{24{lane_b[7]}}, lane_b[7:0]};
      3'b001:  ram_rdata = {{16{lane_h[15]}}, lane_h[15:0]};
      3'b100:  ram_rdata = {24'b0, lane_b[7:0]};
      3'b101:  ram_rdata = {16'b0, lane_h[15:0]};
      default: ram_rdata = ram_word;
    endcase
    case (mmio_sel)
      3'd0:    mmio_rdata = gpio_q;
      3'd1:    mmio_rdata = cycle_q[31:0];
      3'd2:    mmio_rdata = snap_q;
      3'd3:    mmio_rdata = {30'b0, fstat_q};
      3'd4:    mmio_rdata = faddr_q;
      default: mmio_rdata = 32'b0;
    endcase
    read_data_mem = 32'b0;
    if (is_load && ok) read_data_mem = ram_hit ? ram_rdata : mmio_rdata;
  end

  // Store data is lane-replicated so the byte enables alone pick the target bytes.
  always_comb begin
    ram_we = ok & mem_write_mem & ram_hit;
    if (is_byte) begin
      ram_be    = 4'b0001 << alu_result_mem[1:0];
      ram_wdata = {4{write_data_mem[7:0]}};
    end else if (is_half) begin
      ram_be    = 4'b0011 << alu_result_mem[1:0];
      ram_wdata = {2{write_data_mem[15:0]}};
    end else begin
      ram_be    = 4'b1111;
      ram_wdata = write_data_mem;
    end
  end

  always_comb begin
    gpio_d  = gpio_q;
    cycle_d = cycle_q + 64'd1;
    snap_d  = snap_q;
    fstat_d = fstat_q;
    faddr_d = faddr_q;
    if (ok && mem_write_mem && mmio_hit && mmio_sel == 3'd0) gpio_d = write_data_mem;
    if (ok && is_load && mmio_hit && mmio_sel == 3'd1) snap_d = cycle_q[63:32];
    if (ok && mem_write_mem && mmio_hit && mmio_sel == 3'd3)
      fstat_d = fstat_q & ~write_data_mem[1:0];
    // New faults are OR-ed in after the W1C so a same-edge set always wins.
    fstat_d = fstat_d | {fault_dec, fault_mis};
    if ((fstat_q == 2'b00) && (fault_mis || fault_dec)) faddr_d = alu_result_mem;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      gpio_q  <= 32'b0;
      cycle_q <= 64'b0;
      snap_q  <= 32'b0;
      fstat_q <= 2'b00;
      faddr_q <= 32'b0;
    end else begin
      gpio_q  <= gpio_d;
      cycle_q <= cycle_d;
      snap_q  <= snap_d;
      fstat_q <= fstat_d;
      faddr_q <= faddr_d;
    end
  end

  // RAM is not cleared by reset, but a store is dropped if reset is low at the edge.
  always_ff @(posedge clk) begin
    if (reset && ram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) mem_q[ram_idx][8*i +: 8] <= ram_wdata[8*i +: 8];
      end
    end
  end

  assign gpio_out = gpio_q;
  assign fault    = |fstat_q;

endmodule
`default_nettype wire
